seven_seg_scan_ctrl: RTL

Time-multiplexes one 4-bit-to-seven-segment decoder across NUM_DIGITS common-anode digits.
- Accepts a packed hex word over a val/rdy handshake and double-buffers it.
- Drives the shared decoder's input and returns its (active-low) segment output together with a one-hot digit enable.
- Inserts blanking intervals between digits to prevent ghosting.
- Sits between the top-level datapath and the board's display pins.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 14 +
 rtl/seven_seg_scan_ctrl_scan_timer.sv | 32 +++
 rtl/seven_seg_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seven_seg_scan_ctrl_pkg;

  localparam int         NIB_W     = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;  // all segments off (active-low)

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Loadable down-counter with terminal-count flag, shared by dwell and blank intervals.
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; counts every cycle and holds at zero.
//
// Ports: clk, rst_n (sync, active-low), load/load_val (reload request and value),
//        tc (count has reached zero).
module scan_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexes one external hex-to-7-seg decoder across NUM_DIGITS common-anode digits.
// Latency: an accepted word becomes visible at the next frame boundary (<= 1 frame + BLANK_CYCLES).
// Backpressure: in_rdy drops while a word is pending; it rises on the frame boundary cycle.
//
// Ports: clk, rst_n (sync, active-low); in_val/in_rdy/in_data (packed nibbles, digit i at
//        [4i+3:4i]); dec_in/dec_seg (shared decoder); seg_out (active-low), digit_en
//        (one-hot, active-high), frame_done (one-cycle pulse at each frame boundary).
// Build option: define SEVEN_SEG_SCAN_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [NIB_W*NUM_DIGITS-1:0] in_data,
  output logic [NIB_W-1:0]            dec_in,
  input  logic [6:0]                  dec_seg,
  output logic [6:0]                  seg_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_done
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = NIB_W * NUM_DIGITS;

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [DW-1:0]   shadow_q, shadow_n;
  logic [DW-1:0]   pending_q, pending_n;
  logic            pending_full_q, pending_full_n;
  logic            frame_done_q, frame_done_n;

  logic            tmr_load;
  logic [CW-1:0]   tmr_load_val;
  logic            tmr_tc;

  scan_timer #(
    .W       (CW),
    .RST_VAL (CW'(BLANK_CYCLES - 1))
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BLANK;
      idx_q          <= '0;
      shadow_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_n;
      idx_q          <= idx_n;
      shadow_q       <= shadow_n;
      pending_q      <= pending_n;
      pending_full_q <= pending_full_n;
      frame_done_q   <= frame_done_n;
    end
  end

  assign in_rdy = !pending_full_q;

  // Accept and shadow load never coincide: accept needs the pending buffer
  // empty, the boundary load needs it full.
  always_comb begin
    state_n        = state_q;
    idx_n          = idx_q;
    shadow_n       = shadow_q;
    pending_n      = pending_q;
    pending_full_n = pending_full_q;
    frame_done_n   = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_val   = CW'(BLANK_CYCLES - 1);

    if (in_val && in_rdy) begin
      pending_n      = in_data;
      pending_full_n = 1'b1;
    end

    unique case (state_q)
      BLANK: begin
        if (tmr_tc) begin
          state_n      = SHOW;
          tmr_load     = 1'b1;
          tmr_load_val = CW'(DWELL_CYCLES - 1);
        end
      end
      SHOW: begin
        if (tmr_tc) begin
          state_n  = BLANK;
          tmr_load = 1'b1;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            // Frame boundary: the only place the displayed word may change.
            idx_n        = '0;
            frame_done_n = 1'b1;
            if (pending_full_q) begin
              shadow_n       = pending_q;
              pending_full_n = 1'b0;
            end
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: state_n = BLANK;
    endcase
  end

  logic lit;

`ifdef SEVEN_SEG_SCAN_LEADING_ZERO_BLANK_EN
  // True when the current digit and every higher digit hold zero.
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (shadow_q[i*NIB_W +: NIB_W] != '0)) begin
        upper_zero = 1'b0;
      end
    end
  end
  assign lit = (state_q == SHOW) && !((idx_q != '0) && upper_zero);
`else
  assign lit = (state_q == SHOW);
`endif

  always_comb begin
    dec_in   = shadow_q[idx_q*NIB_W +: NIB_W];
    digit_en = '0;
    seg_out  = SEG_BLANK;
    if (lit) begin
      digit_en[idx_q] = 1'b1;
      seg_out         = dec_seg;
    end
  end

  assign frame_done = frame_done_q;

endmodule
